// File: rtl/addsub_pkg.sv
// Shared types and constants for the pipelined adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADDS   = 2'b00,
        OP_SUBS   = 2'b01,
        OP_PADDSB = 2'b10,
        OP_ADDW   = 2'b11
    } op_e;

    localparam int LANE  = 4;
    localparam int MAX_W = 64;

    // Largest positive two's-complement value of width w (0111..1).
    function automatic logic [MAX_W-1:0] sat_max(input int w);
        sat_max = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    endfunction

    // Most negative two's-complement value of width w (1000..0).
    function automatic logic [MAX_W-1:0] sat_min(input int w);
        sat_min = MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe.
// master drives operands and consumes results; slave is the arithmetic block.
interface addsub_pipe_if
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_e              op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_v;
    logic             flag_n;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_v, flag_n
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, flag_z, flag_v, flag_n
    );
endinterface

// File: rtl/cla_nib.sv
// 4-bit carry-lookahead lane. Group generate/propagate do not depend on
// cin, so lanes can be chained without a combinational loop through them.
module cla_nib (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       g,
    output logic       p,
    output logic       c3,
    output logic       ovf
);
    logic [3:0] gi;
    logic [3:0] pi;
    logic       c1;
    logic       c2;
    logic       cout;

    assign gi = a & b;
    assign pi = a ^ b;
    assign g  = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
              | (pi[3] & pi[2] & pi[1] & gi[0]);
    assign p  = &pi;

    // Lookahead carries, lane sum and signed overflow of the lane.
    always_comb begin
        c1   = gi[0] | (pi[0] & cin);
        c2   = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
        c3   = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
             | (pi[2] & pi[1] & pi[0] & cin);
        cout = g | (p & cin);
        sum  = pi ^ {c3, c2, c1, cin};
        ovf  = c3 ^ cout;
    end
endmodule

// File: rtl/addsub_pipe.sv
// Two-stage signed add/sub: stage 1 adds the low half, stage 2 adds the high
// half with the registered carry and applies saturate/wrap/lane modes.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    addsub_pipe_if.slave bus
);
    localparam int HW    = WIDTH / 2;
    localparam int NIB   = HW / LANE;
    localparam int LANES = WIDTH / LANE;

    localparam logic [WIDTH-1:0] SAT_MAX  = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN  = WIDTH'(sat_min(WIDTH));
    localparam logic [LANE-1:0]  LANE_MAX = LANE'(sat_max(LANE));
    localparam logic [LANE-1:0]  LANE_MIN = LANE'(sat_min(LANE));

    // stage 1 datapath
    logic             is_sub;
    logic             is_paddsb;
    logic [WIDTH-1:0] b_eff;
    logic [NIB-1:0]   lo_c, lo_g, lo_p, lo_c3, lo_ovf;
    logic [HW-1:0]    lo_sum;
    logic             lo_cout;

    // stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [HW-1:0]    lo_sum_q, lo_sum_d;
    logic             carry_q, carry_d;
    op_e              op_q, op_d;
    logic [HW-1:0]    a_hi_q, a_hi_d;
    logic [HW-1:0]    b_hi_q, b_hi_d;
    logic [NIB-1:0]   lo_sat_q, lo_sat_d;

    // stage 2 datapath
    logic             s2_paddsb;
    logic [NIB-1:0]   hi_c, hi_g, hi_p, hi_c3, hi_ovf;
    logic [HW-1:0]    hi_sum;
    logic [WIDTH-1:0] raw;
    logic [LANES-1:0] lane_sat;
    logic [WIDTH-1:0] res;
    logic             res_v, res_z, res_n;

    // output registers
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_v_q, flag_v_d;
    logic             flag_n_q, flag_n_d;

    logic             s2_adv;
    logic             in_ready;
    logic             unused_c3;

    // Subtraction is a + ~b + 1, so b is inverted here and cin forced high.
    always_comb begin
        is_sub    = (bus.op == OP_SUBS);
        is_paddsb = (bus.op == OP_PADDSB);
        b_eff     = is_sub ? ~bus.b : bus.b;
    end

    for (genvar i = 0; i < NIB; i++) begin : g_lo
        cla_nib u_nib (
            .a   (bus.a[i*LANE +: LANE]),
            .b   (b_eff[i*LANE +: LANE]),
            .cin (lo_c[i]),
            .sum (lo_sum[i*LANE +: LANE]),
            .g   (lo_g[i]),
            .p   (lo_p[i]),
            .c3  (lo_c3[i]),
            .ovf (lo_ovf[i])
        );
    end

    // Low-half carry chain; PADDSB isolates every lane so nothing crosses.
    always_comb begin
        logic c;
        c = is_sub;
        for (int i = 0; i < NIB; i++) begin
            lo_c[i] = c;
            c       = is_paddsb ? 1'b0 : (lo_g[i] | (lo_p[i] & c));
        end
        lo_cout = c;
    end

    assign s2_paddsb = (op_q == OP_PADDSB);

    for (genvar i = 0; i < NIB; i++) begin : g_hi
        cla_nib u_nib (
            .a   (a_hi_q[i*LANE +: LANE]),
            .b   (b_hi_q[i*LANE +: LANE]),
            .cin (hi_c[i]),
            .sum (hi_sum[i*LANE +: LANE]),
            .g   (hi_g[i]),
            .p   (hi_p[i]),
            .c3  (hi_c3[i]),
            .ovf (hi_ovf[i])
        );
    end

    // High-half carry chain seeded by the carry registered out of stage 1.
    always_comb begin
        logic c;
        c = carry_q;
        for (int i = 0; i < NIB; i++) begin
            hi_c[i] = c;
            c       = s2_paddsb ? 1'b0 : (hi_g[i] | (hi_p[i] & c));
        end
    end

    // Lane overflow already folds carry-into-MSB in, so the raw taps are spare.
    assign unused_c3 = ^{lo_c3, hi_c3};

    // Mode selection: on overflow the raw MSB is the inverse of the true sign,
    // which picks the clamp value for both whole-word and per-lane saturation.
    always_comb begin
        raw      = {hi_sum, lo_sum_q};
        lane_sat = {hi_ovf, lo_sat_q};
        res      = raw;
        res_v    = 1'b0;
        case (op_q)
            OP_ADDS, OP_SUBS: begin
                res_v = hi_ovf[NIB-1];
                if (res_v) begin
                    res = raw[WIDTH-1] ? SAT_MAX : SAT_MIN;
                end
            end
            OP_ADDW: begin
                res_v = hi_ovf[NIB-1];
            end
            OP_PADDSB: begin
                res_v = |lane_sat;
                for (int l = 0; l < LANES; l++) begin
                    if (lane_sat[l]) begin
                        res[l*LANE +: LANE] = raw[l*LANE + LANE - 1] ? LANE_MAX : LANE_MIN;
                    end
                end
            end
            default: ;
        endcase
        res_z = (res == '0);
        res_n = s2_paddsb ? 1'b0 : res[WIDTH-1];
    end

    // Stage 1 refills whenever its contents can move on; the output register
    // advances whenever it is empty or being consumed.
    always_comb begin
        s2_adv      = !out_valid_q || bus.out_ready;
        in_ready    = !s1_valid_q || s2_adv;

        s1_valid_d  = s1_valid_q;
        lo_sum_d    = lo_sum_q;
        carry_d     = carry_q;
        op_d        = op_q;
        a_hi_d      = a_hi_q;
        b_hi_d      = b_hi_q;
        lo_sat_d    = lo_sat_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flag_z_d    = flag_z_q;
        flag_v_d    = flag_v_q;
        flag_n_d    = flag_n_q;

        if (in_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                lo_sum_d = lo_sum;
                carry_d  = lo_cout;
                op_d     = bus.op;
                a_hi_d   = bus.a[WIDTH-1:HW];
                b_hi_d   = b_eff[WIDTH-1:HW];
                lo_sat_d = lo_ovf;
            end
        end

        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = res;
                flag_z_d = res_z;
                flag_v_d = res_v;
                flag_n_d = res_n;
            end
        end
    end

    // Stage 1 pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            lo_sum_q   <= '0;
            carry_q    <= 1'b0;
            op_q       <= OP_ADDS;
            a_hi_q     <= '0;
            b_hi_q     <= '0;
            lo_sat_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            lo_sum_q   <= lo_sum_d;
            carry_q    <= carry_d;
            op_q       <= op_d;
            a_hi_q     <= a_hi_d;
            b_hi_q     <= b_hi_d;
            lo_sat_q   <= lo_sat_d;
        end
    end

    // Output register; holds steady while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flag_z_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            flag_n_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flag_z_q    <= flag_z_d;
            flag_v_q    <= flag_v_d;
            flag_n_q    <= flag_n_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flag_z    = flag_z_q;
    assign bus.flag_v    = flag_v_q;
    assign bus.flag_n    = flag_n_q;
endmodule
